// File: rtl/pwm_ramp_wb_master.sv
// rtl/pwm_ramp_wb_master.sv - Wishbone initiator ramping four PWM duty bytes toward targets
// Optional post-write fault check enabled by `define PWM_RAMP_FAULT_CHECK_EN
module pwm_ramp_wb_master #(
   parameter logic [31:0] BASE_ADDR   = 32'h3000_0000,
   parameter int          TICK_DIV    = 256,
   parameter int          ACK_TIMEOUT = 16
) (
   input  logic        wb_clk_i,
   input  logic        wb_rst_i,
   input  logic        start_i,
   input  logic [31:0] target_i,
   input  logic [7:0]  step_i,
   output logic        busy_o,
   output logic        done_o,
   output logic        fault_o,
   output logic        timeout_o,
   output logic        wbm_cyc_o,
   output logic        wbm_stb_o,
   output logic        wbm_we_o,
   output logic [3:0]  wbm_sel_o,
   output logic [31:0] wbm_adr_o,
   output logic [31:0] wbm_dat_o,
   input  logic [31:0] wbm_dat_i,
   input  logic        wbm_ack_i
);
   localparam int TW = $clog2(TICK_DIV + 1);
   localparam int AW = $clog2(ACK_TIMEOUT + 1);
   localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
   localparam logic [AW-1:0] TO_LAST   = AW'(ACK_TIMEOUT - 1);

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_RD_PWM    = 3'd1,
      ST_WR_PWM    = 3'd2,
      ST_WAIT_TICK = 3'd3,
      ST_ERR       = 3'd4
`ifdef PWM_RAMP_FAULT_CHECK_EN
      , ST_RD_STAT = 3'd5
`endif
   } state_t;

   state_t          r_state, w_state_nxt;
   logic            r_cyc, r_we, r_busy, r_done, r_timeout;
   logic [3:0]      r_sel;
   logic [31:0]     r_adr, r_dat, r_tgt;
   logic [7:0]      r_step;
   logic [TW-1:0]   r_tick_cnt;
   logic [AW-1:0]   r_to_cnt;
   logic [31:0]     w_new;
   logic [3:0]      w_sel_new;
   logic [7:0]      w_cur, w_tgt, w_byte;
   logic            w_ack, w_to, w_bus_state, w_launch, w_is_wr, w_is_stat, w_accept;
   logic            w_fault_hit;

   assign w_ack    = r_cyc & wbm_ack_i;
   assign w_to     = r_cyc & ~wbm_ack_i & (r_to_cnt == TO_LAST);
   assign w_is_wr  = (r_state == ST_WR_PWM);
   assign w_accept = (r_state == ST_IDLE) & start_i;
`ifdef PWM_RAMP_FAULT_CHECK_EN
   assign w_is_stat   = (r_state == ST_RD_STAT);
   assign w_fault_hit = w_ack & w_is_stat &
                        (wbm_dat_i[7] | wbm_dat_i[15] | wbm_dat_i[23] | wbm_dat_i[31]);
`else
   assign w_is_stat   = 1'b0;
   assign w_fault_hit = 1'b0;
`endif
   assign w_bus_state = (r_state == ST_RD_PWM) | w_is_wr | w_is_stat;
   // A new bus cycle only starts from an idle bus, which keeps one gap cycle between strobes
   assign w_launch    = w_bus_state & ~r_cyc;

   // Per-byte step toward target, compared in 9 bits so neither direction can wrap
   always_comb begin
      w_new     = '0;
      w_sel_new = '0;
      w_cur     = '0;
      w_tgt     = '0;
      w_byte    = '0;
      for (int n = 0; n < 4; n++) begin
         w_cur = wbm_dat_i[8*n +: 8];
         w_tgt = r_tgt[8*n +: 8];
         if (w_cur < w_tgt)
            w_byte = (({1'b0, w_cur} + {1'b0, r_step}) > {1'b0, w_tgt}) ? w_tgt : w_cur + r_step;
         else if (w_cur > w_tgt)
            w_byte = ({1'b0, w_cur} < ({1'b0, w_tgt} + {1'b0, r_step})) ? w_tgt : w_cur - r_step;
         else
            w_byte = w_cur;
         w_new[8*n +: 8] = w_byte;
         w_sel_new[n]    = (w_byte != w_cur);
      end
   end

   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) r_state <= ST_IDLE;
      else          r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE:      if (start_i) w_state_nxt = ST_RD_PWM;
         ST_RD_PWM:    if (w_to) w_state_nxt = ST_ERR;
                       else if (w_ack) w_state_nxt = (w_sel_new == 4'h0) ? ST_IDLE : ST_WR_PWM;
`ifdef PWM_RAMP_FAULT_CHECK_EN
         ST_WR_PWM:    if (w_to) w_state_nxt = ST_ERR;
                       else if (w_ack) w_state_nxt = ST_RD_STAT;
         ST_RD_STAT:   if (w_to) w_state_nxt = ST_ERR;
                       else if (w_ack) w_state_nxt = w_fault_hit ? ST_ERR : ST_WAIT_TICK;
`else
         ST_WR_PWM:    if (w_to) w_state_nxt = ST_ERR;
                       else if (w_ack) w_state_nxt = ST_WAIT_TICK;
`endif
         ST_WAIT_TICK: if (r_tick_cnt == TICK_LAST) w_state_nxt = ST_RD_PWM;
         ST_ERR:       w_state_nxt = ST_IDLE;
         default:      w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         r_cyc      <= 1'b0;
         r_we       <= 1'b0;
         r_sel      <= '0;
         r_adr      <= '0;
         r_dat      <= '0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
         r_timeout  <= 1'b0;
         r_tgt      <= '0;
         r_step     <= '0;
         r_tick_cnt <= '0;
         r_to_cnt   <= '0;
      end else begin
         r_done     <= (r_state == ST_RD_PWM) & (w_state_nxt == ST_IDLE);
         r_tick_cnt <= (r_state == ST_WAIT_TICK) ? r_tick_cnt + 1'b1 : '0;
         if (w_accept) begin
            r_tgt     <= target_i;
            r_step    <= (step_i == 8'd0) ? 8'd1 : step_i;
            r_busy    <= 1'b1;
            r_timeout <= 1'b0;
         end else if (r_busy && (w_state_nxt == ST_IDLE || w_state_nxt == ST_ERR)) begin
            r_busy <= 1'b0;
         end
         if (w_launch) begin
            r_cyc    <= 1'b1;
            r_we     <= w_is_wr;
            r_sel    <= w_is_wr ? r_sel : 4'hF;
            r_adr    <= BASE_ADDR + (w_is_stat ? 32'h8 : 32'h0);
            r_to_cnt <= '0;
         end else if (r_cyc) begin
            if (wbm_ack_i) begin
               r_cyc <= 1'b0;
            end else if (w_to) begin
               r_cyc     <= 1'b0;
               r_timeout <= 1'b1;
            end else begin
               r_to_cnt <= r_to_cnt + 1'b1;
            end
         end
         if (w_ack && r_state == ST_RD_PWM) begin
            r_dat <= w_new;
            r_sel <= w_sel_new;
         end
      end
   end

`ifdef PWM_RAMP_FAULT_CHECK_EN
   logic r_fault;
   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i)         r_fault <= 1'b0;
      else if (w_accept)    r_fault <= 1'b0;
      else if (w_fault_hit) r_fault <= 1'b1;
   end
   assign fault_o = r_fault;
`else
   assign fault_o = 1'b0;
`endif

   assign busy_o    = r_busy;
   assign done_o    = r_done;
   assign timeout_o = r_timeout;
   assign wbm_cyc_o = r_cyc;
   assign wbm_stb_o = r_cyc;
   assign wbm_we_o  = r_we;
   assign wbm_sel_o = r_sel;
   assign wbm_adr_o = r_adr;
   assign wbm_dat_o = r_dat;
endmodule

// File: tb/tb_pwm_ramp_wb_master.sv
// tb/tb_pwm_ramp_wb_master.sv - self-checking bench for pwm_ramp_wb_master
// Responder models the PWM driver; expected writes come from a clamp-based ramp model
module tb_pwm_ramp_wb_master;
   localparam logic [31:0] BASE = 32'h3000_0000;
   localparam int TICK  = 8;
   localparam int ATO   = 16;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start_i = 1'b0;
   logic [31:0] target_i = '0;
   logic [7:0]  step_i = '0;
   logic        busy_o, done_o, fault_o, timeout_o;
   logic        wbm_cyc_o, wbm_stb_o, wbm_we_o;
   logic [3:0]  wbm_sel_o;
   logic [31:0] wbm_adr_o, wbm_dat_o;
   logic [31:0] rdata = '0;
   logic        ack = 1'b0;

   pwm_ramp_wb_master #(.BASE_ADDR(BASE), .TICK_DIV(TICK), .ACK_TIMEOUT(ATO)) dut (
      .wb_clk_i(clk), .wb_rst_i(rst), .start_i(start_i), .target_i(target_i), .step_i(step_i),
      .busy_o(busy_o), .done_o(done_o), .fault_o(fault_o), .timeout_o(timeout_o),
      .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o), .wbm_we_o(wbm_we_o), .wbm_sel_o(wbm_sel_o),
      .wbm_adr_o(wbm_adr_o), .wbm_dat_o(wbm_dat_o), .wbm_dat_i(rdata), .wbm_ack_i(ack)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   logic        load = 1'b0;
   logic        noack = 1'b0;
   logic [31:0] preset = '0;
   logic [31:0] stat_pre = '0;
   logic [31:0] mem = '0;
   logic [31:0] stat = '0;
   logic        prev_cyc = 1'b0;
   int cyc_cnt = 0, wr_n = 0, rd_n = 0, stat_n = 0, done_n = 0, bus_n = 0, cyc_hi = 0, stb_bad = 0;
   logic [31:0] wr_dat [0:511];
   logic [3:0]  wr_sel [0:511];
   int          wr_at  [0:511];

   // Driver responder: one-cycle ack latency, never acks two cycles running
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         ack      <= 1'b0;
         prev_cyc <= 1'b0;
      end else begin
         cyc_cnt  <= cyc_cnt + 1;
         prev_cyc <= wbm_cyc_o;
         if (wbm_cyc_o !== wbm_stb_o) stb_bad <= stb_bad + 1;
         if (load) begin
            mem <= preset; stat <= stat_pre;
            wr_n <= 0; rd_n <= 0; stat_n <= 0; done_n <= 0; bus_n <= 0; cyc_hi <= 0;
         end else begin
            if (done_o) done_n <= done_n + 1;
            if (wbm_cyc_o) cyc_hi <= cyc_hi + 1;
            if (wbm_cyc_o && !prev_cyc) bus_n <= bus_n + 1;
         end
         if (wbm_cyc_o && wbm_stb_o && !ack && !noack && !load) begin
            ack <= 1'b1;
            if (wbm_we_o) begin
               for (int b = 0; b < 4; b++)
                  if (wbm_sel_o[b]) mem[8*b +: 8] <= wbm_dat_o[8*b +: 8];
               if (wr_n < 512) begin
                  wr_dat[wr_n] <= wbm_dat_o; wr_sel[wr_n] <= wbm_sel_o; wr_at[wr_n] <= cyc_cnt;
               end
               wr_n <= wr_n + 1;
            end else if (wbm_adr_o == BASE) begin
               rdata <= mem; rd_n <= rd_n + 1;
            end else if (wbm_adr_o == BASE + 32'h8) begin
               rdata <= stat; stat_n <= stat_n + 1;
            end else begin
               rdata <= 32'hDEAD_BEEF;
            end
         end else begin
            ack <= 1'b0;
         end
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Reference ramp: each byte moves toward target by at most step (step 0 means 1)
   logic [31:0] exp_dat [0:511];
   logic [3:0]  exp_sel [0:511];
   int          exp_n;
   task automatic model(input logic [31:0] cur, input logic [31:0] tgt, input logic [7:0] st);
      int s, cv, tv, d;
      logic [31:0] nxt;
      logic [3:0]  sel;
      s = (st == 0) ? 1 : int'(st);
      exp_n = 0;
      for (int it = 0; it < 300; it++) begin
         nxt = cur; sel = '0;
         for (int b = 0; b < 4; b++) begin
            cv = int'(cur[8*b +: 8]); tv = int'(tgt[8*b +: 8]);
            d = tv - cv;
            if (d > s) d = s;
            if (d < -s) d = -s;
            nxt[8*b +: 8] = 8'(cv + d);
            sel[b] = (d != 0);
         end
         if (sel == 4'h0) break;
         exp_dat[exp_n] = nxt; exp_sel[exp_n] = sel; exp_n++;
         cur = nxt;
      end
   endtask

   task automatic load_resp(input logic [31:0] p, input logic [31:0] s);
      preset = p; stat_pre = s; load = 1'b1;
      @(posedge clk); #1;
      load = 1'b0;
   endtask

   task automatic do_start(input logic [31:0] t, input logic [7:0] s);
      target_i = t; step_i = s; start_i = 1'b1;
      @(posedge clk); #1;
      start_i = 1'b0;
   endtask

   task automatic wait_idle(input int budget, input string tag);
      int k = 0;
      while (busy_o && k < budget) begin @(posedge clk); #1; k++; end
      chk(tag, {31'd0, busy_o}, 32'd0);
      repeat (3) @(posedge clk);
      #1;
   endtask

   task automatic check_ramp(input string tag, input logic [31:0] tgt);
      int bad_gap = 0;
      chk({tag, "_nwr"}, wr_n, exp_n);
      for (int i = 0; i < exp_n && i < wr_n; i++) begin
         chk($sformatf("%s_dat%0d", tag, i), wr_dat[i], exp_dat[i]);
         chk($sformatf("%s_sel%0d", tag, i), {28'd0, wr_sel[i]}, {28'd0, exp_sel[i]});
         if (i > 0 && (wr_at[i] - wr_at[i-1] < TICK || wr_at[i] - wr_at[i-1] > TICK + 12)) bad_gap++;
      end
      chk({tag, "_gap"}, bad_gap, 0);
      chk({tag, "_final"}, mem, tgt);
      chk({tag, "_done"}, done_n, 1);
      chk({tag, "_tmo"}, {31'd0, timeout_o}, 32'd0);
   endtask

   task automatic run_ramp(input string tag, input logic [31:0] p, input logic [31:0] t, input logic [7:0] s);
      load_resp(p, 32'd0);
      model(p, t, s);
      do_start(t, s);
      wait_idle((exp_n + 2) * (TICK + 24) + 50, {tag, "_busy"});
      check_ramp(tag, t);
   endtask

   initial begin
      int found;
      logic [31:0] rp, rt;
      logic [7:0]  rs;
      int snap;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_cyc", {31'd0, wbm_cyc_o}, 0);
      chk("rst_stb", {31'd0, wbm_stb_o}, 0);
      chk("rst_we", {31'd0, wbm_we_o}, 0);
      chk("rst_busy", {31'd0, busy_o}, 0);
      chk("rst_flags", {29'd0, done_o, fault_o, timeout_o}, 0);
      chk("rst_sel", {28'd0, wbm_sel_o}, 0);
      chk("rst_adr", wbm_adr_o, 0);
      chk("rst_dat", wbm_dat_o, 0);
      rst = 1'b0;
      repeat (2) @(posedge clk);
      #1;

      run_ramp("tp1", 32'h7F7F_7F7F, 32'h807E_7F90, 8'h10);
      chk("tp1_w0", wr_dat[0], 32'h807E_7F8F);
      chk("tp1_s0", {28'd0, wr_sel[0]}, 32'b1101);
      chk("tp1_w1", wr_dat[1], 32'h807E_7F90);
      chk("tp1_s1", {28'd0, wr_sel[1]}, 32'b0001);

      run_ramp("eq", 32'h7F7F_7F7F, 32'h7F7F_7F7F, 8'h10);
      chk("eq_reads", rd_n, 1);

      run_ramp("st0", 32'h0, 32'h0000_0003, 8'h00);
      chk("st0_w2", wr_dat[2], 32'h0000_0003);

      for (int r = 0; r < 4; r++) begin
         rp = $urandom; rt = $urandom; rs = 8'($urandom_range(16, 255));
         run_ramp($sformatf("rnd%0d", r), rp, rt, rs);
      end

      // Fault on status read after first write
      load_resp(32'h0, 32'h0000_8000);
      do_start(32'h0000_0040, 8'h10);
`ifdef PWM_RAMP_FAULT_CHECK_EN
      wait_idle(200, "flt_busy");
      chk("flt_flag", {31'd0, fault_o}, 1);
      chk("flt_nwr", wr_n, 1);
      snap = bus_n;
      repeat (40) @(posedge clk);
      #1;
      chk("flt_quiet", bus_n, snap);
      load_resp(32'h0, 32'h0);
      do_start(32'h0000_0001, 8'h01);
      chk("flt_clear", {31'd0, fault_o}, 0);
      wait_idle(200, "flt2_busy");
`else
      wait_idle(400, "flt_busy");
      chk("flt_flag", {31'd0, fault_o}, 0);
      chk("flt_nstat", stat_n, 0);
      chk("flt_nwr", wr_n, 4);
      snap = bus_n;
      chk("flt_final", mem, 32'h0000_0040);
`endif

      // No ack: bus cycle abandoned after ACK_TIMEOUT cycles
      load_resp(32'h0, 32'h0);
      noack = 1'b1;
      do_start(32'h0000_0010, 8'h01);
      wait_idle(ATO + 20, "to_busy");
      chk("to_flag", {31'd0, timeout_o}, 1);
      chk("to_cychi", cyc_hi, ATO);
      chk("to_cyc", {31'd0, wbm_cyc_o}, 0);
      noack = 1'b0;
      load_resp(32'h0, 32'h0);
      do_start(32'h0000_0001, 8'h01);
      chk("to_clear", {31'd0, timeout_o}, 0);
      wait_idle(200, "to2_busy");

      // Start while busy is ignored
      load_resp(32'h0, 32'h0);
      model(32'h0, 32'h0000_0010, 8'h01);
      do_start(32'h0000_0010, 8'h01);
      repeat (20) @(posedge clk);
      #1;
      do_start(32'h0101_0101, 8'h80);
      wait_idle((exp_n + 2) * (TICK + 24), "ign_busy");
      check_ramp("ign", 32'h0000_0010);

      // Reset asserted while a write is on the bus
      load_resp(32'h0, 32'h0);
      do_start(32'h0000_00FF, 8'h01);
      found = 0;
      for (int k = 0; k < 200 && found == 0; k++) begin
         if (wbm_cyc_o && wbm_we_o) found = 1;
         else begin @(posedge clk); #1; end
      end
      chk("rw_reach", found, 1);
      #2 rst = 1'b1;
      #1;
      chk("rw_cyc", {31'd0, wbm_cyc_o}, 0);
      chk("rw_stb", {31'd0, wbm_stb_o}, 0);
      chk("rw_flags", {28'd0, busy_o, done_o, fault_o, timeout_o}, 0);
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;
      chk("rw_idle", {31'd0, wbm_cyc_o}, 0);
      run_ramp("post", 32'h0000_0005, 32'h0000_0007, 8'h01);

      chk("cyc_eq_stb", stb_bad, 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
